ex4_31_exerciser: RTL and testbench

//  Self-checking stimulus/response engine for the registered ex4_31 datapath.

---
 rtl/ex4_31_exerciser_if.sv | 15 +
 rtl/ex4_31_exerciser.sv | 147 ++++++++++++++
 tb/tb_ex4_31_exerciser.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex4_31_exerciser_if.sv
// Stimulus/response bus between the ex4_31 exerciser and the datapath it drives.
// The exerciser drives a..d and reads x/y back after the datapath latency.
interface ex4_31_exerciser_if;
    logic a;
    logic b;
    logic c;
    logic d;
    logic x;
    logic y;

    // Exerciser side: drives the vector, observes the response.
    modport master (output a, output b, output c, output d, input x, input y);
    // Datapath side: consumes the vector, returns the response.
    modport slave  (input a, input b, input c, input d, output x, output y);
endinterface

// File: rtl/ex4_31_exerciser.sv
// Self-checking stimulus/response engine for the registered ex4_31 datapath.
// Walks every {a,b,c,d} pattern, checks x=(a&b)|c and y=~(x|d) after LATENCY
// cycles, counts mismatching vectors (saturating) and latches the first one.
//
// Bus semantics: there is no handshake. One vector is presented per cycle
// while busy in RUN; the response to the vector held during cycle k is
// sampled at the edge that ends cycle k+LATENCY. start is a level that is
// only looked at in IDLE or DONE.
module ex4_31_exerciser #(
    parameter int LATENCY     = 2,
    parameter int NUM_VECTORS = 16,
    parameter int ERR_W       = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    ex4_31_exerciser_if.master    bus,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_count,
    output logic [3:0]            fail_vec,
    output logic [1:0]            state_dbg
);
    localparam int VW = $clog2(NUM_VECTORS + 1);
    localparam int DW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [VW-1:0]   vec_cnt;     // vectors issued so far in this run
    logic [3:0]      vec_idx;     // next vector pattern, wraps mod 16
    logic [DW-1:0]   drain_cnt;

    // Expected-response pipe: one entry per cycle, tagged with its vector.
    logic [LATENCY-1:0] pipe_v;
    logic [LATENCY-1:0] pipe_x;
    logic [LATENCY-1:0] pipe_y;
    logic [3:0]         pipe_vec [LATENCY];

    logic             exp_x_now;
    logic             exp_y_now;
    logic             mismatch;
    logic [ERR_W-1:0] err_next;

    assign state_dbg = state;

    // Golden response for the vector currently on the bus, and the compare of
    // the oldest pipe entry against what the datapath returns this cycle.
    always_comb begin
        exp_x_now = (bus.a & bus.b) | bus.c;
        exp_y_now = ~(exp_x_now | bus.d);
        mismatch  = pipe_v[LATENCY-1] &&
                    ((bus.x != pipe_x[LATENCY-1]) || (bus.y != pipe_y[LATENCY-1]));
        err_next  = err_count;
        if (mismatch && (err_count != {ERR_W{1'b1}})) begin
            err_next = err_count + 1'b1;
        end
    end

    // Run-control FSM with registered stimulus, status and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bus.a     <= 1'b0;
            bus.b     <= 1'b0;
            bus.c     <= 1'b0;
            bus.d     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
            vec_cnt   <= '0;
            vec_idx   <= '0;
            drain_cnt <= '0;
            pipe_v    <= '0;
            pipe_x    <= '0;
            pipe_y    <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_vec[i] <= '0;
            end
        end else begin
            // Shift the expected pipe; only cycles spent in RUN carry a vector.
            for (int i = LATENCY - 1; i > 0; i--) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_x[i]   <= pipe_x[i-1];
                pipe_y[i]   <= pipe_y[i-1];
                pipe_vec[i] <= pipe_vec[i-1];
            end
            pipe_v[0]   <= (state == RUN);
            pipe_x[0]   <= exp_x_now;
            pipe_y[0]   <= exp_y_now;
            pipe_vec[0] <= {bus.a, bus.b, bus.c, bus.d};

            // Accumulate results; the first mismatch is the one with err_count still 0.
            err_count <= err_next;
            if (mismatch && (err_count == '0)) begin
                fail_vec <= pipe_vec[LATENCY-1];
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        {bus.a, bus.b, bus.c, bus.d} <= 4'd0;
                        vec_idx   <= 4'd1;
                        vec_cnt   <= VW'(1);
                        err_count <= '0;
                        fail_vec  <= '0;
                        pass      <= 1'b0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        pipe_v    <= '0;
                    end
                end
                RUN: begin
                    if (vec_cnt == VW'(NUM_VECTORS)) begin
                        state     <= DRAIN;
                        {bus.a, bus.b, bus.c, bus.d} <= 4'd0;
                        drain_cnt <= '0;
                    end else begin
                        {bus.a, bus.b, bus.c, bus.d} <= vec_idx;
                        vec_idx <= vec_idx + 4'd1;
                        vec_cnt <= vec_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DW'(LATENCY - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex4_31_exerciser.sv
// Bench for ex4_31_exerciser: a behavioural ex4_31 datapath with selectable
// latency and faults feeds two exercisers (ERR_W=5 and ERR_W=3); a reference
// model predicts err_count, fail_vec and pass for each run.
module tb_ex4_31_exerciser;
    localparam int N = 16;
    localparam int L = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    logic start;
    always #5 clk = ~clk;

    ex4_31_exerciser_if bus1 ();
    ex4_31_exerciser_if bus2 ();

    logic       busy1, done1, pass1;
    logic [4:0] err1;
    logic [3:0] fv1;
    logic [1:0] st1;
    logic       busy2, done2, pass2;
    logic [2:0] err2;
    logic [3:0] fv2;
    logic [1:0] st2;

    ex4_31_exerciser #(.LATENCY(L), .NUM_VECTORS(N), .ERR_W(5)) u_dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_vec(fv1), .state_dbg(st1)
    );

    ex4_31_exerciser #(.LATENCY(L), .NUM_VECTORS(N), .ERR_W(3)) u_sat (
        .clk(clk), .reset(reset), .start(start), .bus(bus2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_vec(fv2), .state_dbg(st2)
    );

    // ---------------- behavioural datapath ----------------
    // fault_mode: 0 golden, 1 y stuck-at-0, 2 x stuck-at-0, 3 random per-vector flips
    int   dut_lat    = 2;
    int   fault_mode = 0;
    bit   flip_x [16];
    bit   flip_y [16];
    logic [3:0] s1 = 4'd0;
    logic [3:0] s2 = 4'd0;

    function automatic logic [1:0] dut_fn(input logic [3:0] v, input int mode);
        logic gx, gy;
        gx = (v[3] & v[2]) | v[1];
        gy = ~(gx | v[0]);
        case (mode)
            1: gy = 1'b0;
            2: gx = 1'b0;
            3: begin
                gx = gx ^ flip_x[v];
                gy = gy ^ flip_y[v];
            end
            default: ;
        endcase
        return {gx, gy};
    endfunction

    always @(posedge clk) begin
        s1 <= {bus1.a, bus1.b, bus1.c, bus1.d};
        s2 <= s1;
    end

    logic [1:0] resp;
    assign resp = dut_fn((dut_lat == 1) ? s1 : s2, fault_mode);
    assign bus1.x = resp[1];
    assign bus1.y = resp[0];
    assign bus2.x = resp[1];
    assign bus2.y = resp[0];

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_q [$];

    function automatic logic [3:0] vec_at(input int j);
        return (j < N) ? 4'(j % 16) : 4'd0;
    endfunction

    // Predicted results of a full run from the datapath behaviour.
    int         m_err;
    logic [3:0] m_fail;

    task automatic model_run();
        logic [1:0] g, r;
        m_err  = 0;
        m_fail = 4'd0;
        for (int k = 0; k < N; k++) begin
            g = dut_fn(vec_at(k), 0);
            r = dut_fn(vec_at(k + L - dut_lat), fault_mode);
            if (r != g) begin
                if (m_err == 0) m_fail = vec_at(k);
                m_err++;
            end
        end
    endtask

    // ---------------- driver / checker tasks ----------------
    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus1.a, bus1.b, bus1.c, bus1.d, busy1, done1, pass1, err1, fv1} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 0",
                     {bus1.a, bus1.b, bus1.c, bus1.d, busy1, done1, pass1, err1, fv1});
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy1, done1, err1, fv1} !== 11'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b required 0", {busy1, done1, err1, fv1});
        end
    endtask

    // Starts a run and checks the vector stream, status timing and results.
    task automatic run_check(input int mode, input int lat, input bit hold_start, input string name);
        int         e5, e3;
        logic [3:0] got_v, want_v;
        fault_mode = mode;
        dut_lat    = lat;
        model_run();
        e5 = (m_err > 31) ? 31 : m_err;
        e3 = (m_err > 7) ? 7 : m_err;
        exp_q.delete();
        for (int c = 0; c <= N + L; c++) exp_q.push_back(vec_at(c));

        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);   // E0
        #1;
        if (!hold_start) start = 1'b0;
        n_checks++;
        if ({busy1, done1, pass1, err1, fv1} !== {1'b1, 1'b0, 1'b0, 5'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL %s_e0_status: got %b required 1_0_0_00000_0000",
                     name, {busy1, done1, pass1, err1, fv1});
        end
        for (int c = 0; c <= N + L; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (hold_start && c == N + L - 1) start = 1'b0;
            got_v  = {bus1.a, bus1.b, bus1.c, bus1.d};
            want_v = exp_q.pop_front();
            n_checks++;
            if (got_v !== want_v) begin
                n_fail++;
                $display("FAIL %s_vector c=%0d: got %b required %b", name, c, got_v, want_v);
            end
            n_checks++;
            if ({busy1, done1} !== ((c < N + L) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL %s_busy_done c=%0d: got %b required %b",
                         name, c, {busy1, done1}, (c < N + L) ? 2'b10 : 2'b01);
            end
        end
        n_checks++;
        if (err1 !== 5'(e5)) begin
            n_fail++;
            $display("FAIL %s_err_count: got %0d required %0d", name, err1, e5);
        end
        n_checks++;
        if (fv1 !== m_fail) begin
            n_fail++;
            $display("FAIL %s_fail_vec: got %b required %b", name, fv1, m_fail);
        end
        n_checks++;
        if (pass1 !== (m_err == 0)) begin
            n_fail++;
            $display("FAIL %s_pass: got %b required %b", name, pass1, (m_err == 0));
        end
        n_checks++;
        if ({err2, fv2, pass2, done2} !== {3'(e3), m_fail, (m_err == 0), 1'b1}) begin
            n_fail++;
            $display("FAIL %s_sat_results: got %b required %b", name,
                     {err2, fv2, pass2, done2}, {3'(e3), m_fail, (m_err == 0), 1'b1});
        end
        // DONE must hold its results while start stays low.
        @(posedge clk);
        #1;
        n_checks++;
        if ({done1, busy1, err1, fv1} !== {1'b1, 1'b0, 5'(e5), m_fail}) begin
            n_fail++;
            $display("FAIL %s_done_hold: got %b required %b", name,
                     {done1, busy1, err1, fv1}, {1'b1, 1'b0, 5'(e5), m_fail});
        end
    endtask

    task automatic test_golden();
        run_check(0, 2, 1'b0, "golden");
    endtask

    task automatic test_stuck_y();
        run_check(1, 2, 1'b0, "stuck_y");
    endtask

    task automatic test_stuck_x();
        run_check(2, 2, 1'b0, "stuck_x");
    endtask

    task automatic test_latency_mismatch();
        run_check(0, 1, 1'b0, "lat_mismatch");
        n_checks++;
        if (err1 === 5'd0 || pass1 !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_mismatch_detect: got err=%0d pass=%b required err!=0 pass=0", err1, pass1);
        end
    endtask

    task automatic test_random_faults();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) begin
                flip_x[i] = ($urandom_range(0, 3) == 0);
                flip_y[i] = ($urandom_range(0, 3) == 0);
            end
            run_check(3, (r == 2) ? 1 : 2, 1'b0, "random");
        end
    endtask

    task automatic test_reset_mid_run();
        fault_mode = 0;
        dut_lat    = 2;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);   // E0
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus1.a, bus1.b, bus1.c, bus1.d, busy1, done1, pass1, err1, fv1} !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_run_reset: got %b required 0",
                     {bus1.a, bus1.b, bus1.c, bus1.d, busy1, done1, pass1, err1, fv1});
        end
        @(negedge clk);
        reset = 1'b0;
        run_check(0, 2, 1'b0, "after_reset");
    endtask

    task automatic test_start_held();
        run_check(0, 2, 1'b1, "start_held");
    endtask

    task automatic test_back_to_back();
        run_check(1, 2, 1'b0, "b2b_first");
        run_check(2, 2, 1'b0, "b2b_second");
        run_check(0, 2, 1'b0, "b2b_third");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_golden();
        test_stuck_y();
        test_stuck_x();
        test_latency_mismatch();
        test_random_faults();
        test_reset_mid_run();
        test_start_held();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
